// File: rtl/i2c_slave_regs_if.sv
// Pad-side I2C lines plus the local register-file port of i2c_slave_regs.
// The slave modport is the register block; the master modport is whatever drives it.
interface i2c_slave_regs_if;
    logic       scl_pad_i;
    logic       sda_pad_i;
    logic       sda_pad_o;
    logic       sda_padoen_o;
    logic [3:0] loc_adr;
    logic       loc_we;
    logic [7:0] loc_dat_i;
    logic [7:0] loc_dat_o;
    logic       busy_o;
    logic       wr_evt_o;
    logic [3:0] wr_adr_o;

    modport slave (
        input  scl_pad_i, sda_pad_i, loc_adr, loc_we, loc_dat_i,
        output sda_pad_o, sda_padoen_o, loc_dat_o, busy_o, wr_evt_o, wr_adr_o
    );

    modport master (
        output scl_pad_i, sda_pad_i, loc_adr, loc_we, loc_dat_i,
        input  sda_pad_o, sda_padoen_o, loc_dat_o, busy_o, wr_evt_o, wr_adr_o
    );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target (7-bit address) with a 16 x 8-bit register file and a local parallel port.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample glitch filter on SCL/SDA.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    i2c_slave_regs_if.slave bus
);
    localparam int DATA_W = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_ACK    = 3'd2;
    localparam logic [2:0] S_PTR    = 3'd3;
    localparam logic [2:0] S_WDATA  = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;
    localparam logic [2:0] S_MACK   = 3'd6;
    localparam logic [2:0] S_IGNORE = 3'd7;

    logic              scl_p0, scl_p1, sda_p0, sda_p1;
    logic              scl_c, sda_c, scl_d, sda_d;
    logic              scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]        state, nxt;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] rx_byte;
    logic              ack_drv, mack_ok, addr_ack;
    logic [3:0]        ptr;
    logic              oen, busy, wr_evt;
    logic [3:0]        wr_adr;
    logic              i2c_we;
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] loc_dat;

    // Stage p0/p1: two-flop synchronizers, idle bus level after reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p0 <= bus.scl_pad_i;
            scl_p1 <= scl_p0;
            sda_p0 <= bus.sda_pad_i;
            sda_p1 <= sda_p0;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_f, sda_f;

    // Filter stage: follow the line only after three equal synchronized samples
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_p1};
            sda_hist <= {sda_hist[0], sda_p1};
            if (scl_p1 == scl_hist[0] && scl_hist[0] == scl_hist[1])
                scl_f <= scl_hist[0];
            if (sda_p1 == sda_hist[0] && sda_hist[0] == sda_hist[1])
                sda_f <= sda_hist[0];
        end
    end

    assign scl_c = scl_f;
    assign sda_c = sda_f;
`else
    assign scl_c = scl_p1;
    assign sda_c = sda_p1;
`endif

    // Edge-detect stage on the conditioned lines
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_c;
            sda_d <= sda_c;
        end
    end

    assign scl_rise  = scl_c & ~scl_d;
    assign scl_fall  = ~scl_c & scl_d;
    assign start_det = scl_c & scl_d & sda_d & ~sda_c;
    assign stop_det  = scl_c & scl_d & ~sda_d & sda_c;
    assign rx_byte   = {sh[6:0], sda_c};
    assign addr_ack  = (nxt == S_PTR) || (nxt == S_RDATA);
    assign i2c_we    = (state == S_WDATA) && scl_rise && (bit_cnt == 4'd7);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= S_IDLE;
            nxt     <= S_IDLE;
            bit_cnt <= 4'd0;
            sh      <= '0;
            ack_drv <= 1'b0;
            mack_ok <= 1'b0;
            ptr     <= 4'd0;
            oen     <= 1'b1;
            busy    <= 1'b0;
            wr_evt  <= 1'b0;
            wr_adr  <= 4'd0;
        end else begin
            wr_evt <= 1'b0;
            if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= 4'd0;
                oen     <= 1'b1;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state <= S_IDLE;
                oen   <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (scl_rise) begin
                            sh      <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                ack_drv <= 1'b0;
                                case (state)
                                    S_ADDR: begin
                                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                                            state <= S_ACK;
                                            nxt   <= rx_byte[0] ? S_RDATA : S_PTR;
                                        end else begin
                                            state <= S_IGNORE;
                                        end
                                    end
                                    S_PTR: begin
                                        ptr   <= rx_byte[3:0];
                                        state <= S_ACK;
                                        nxt   <= S_WDATA;
                                    end
                                    default: begin
                                        wr_evt <= 1'b1;
                                        wr_adr <= ptr;
                                        ptr    <= ptr + 4'd1;
                                        state  <= S_ACK;
                                        nxt    <= S_WDATA;
                                    end
                                endcase
                            end
                        end
                    end
                    // First fall after the 8th bit drives ACK, the next one hands off
                    S_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                ack_drv <= 1'b1;
                                oen     <= 1'b0;
                                if (addr_ack)
                                    busy <= 1'b1;
                            end else begin
                                state   <= nxt;
                                ack_drv <= 1'b0;
                                bit_cnt <= 4'd0;
                                if (nxt == S_RDATA) begin
                                    sh  <= {regs[ptr][6:0], 1'b1};
                                    oen <= regs[ptr][7];
                                end else begin
                                    oen <= 1'b1;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                oen     <= 1'b1;
                                ptr     <= ptr + 4'd1;
                                mack_ok <= 1'b0;
                                state   <= S_MACK;
                            end else begin
                                oen <= sh[7];
                                sh  <= {sh[6:0], 1'b1};
                            end
                        end
                    end
                    S_MACK: begin
                        if (scl_rise) begin
                            if (sda_c) begin
                                state <= S_IGNORE;
                                busy  <= 1'b0;
                            end else begin
                                mack_ok <= 1'b1;
                            end
                        end else if (scl_fall && mack_ok) begin
                            state   <= S_RDATA;
                            bit_cnt <= 4'd0;
                            sh      <= {regs[ptr][6:0], 1'b1};
                            oen     <= regs[ptr][7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register file: an I2C write to the same index overrides the local write
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
            loc_dat <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (i2c_we && ptr == 4'(i))
                    regs[i] <= rx_byte;
                else if (bus.loc_we && bus.loc_adr == 4'(i))
                    regs[i] <= bus.loc_dat_i;
            end
            loc_dat <= regs[bus.loc_adr];
        end
    end

    assign bus.sda_pad_o    = 1'b0;
    assign bus.sda_padoen_o = oen;
    assign bus.loc_dat_o    = loc_dat;
    assign bus.busy_o       = busy;
    assign bus.wr_evt_o     = wr_evt;
    assign bus.wr_adr_o     = wr_adr;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_slave_regs;
    logic clk = 1'b0;
    logic rst;
    logic m_scl, m_sda;
    logic sda_line;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] evt_adr [$];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int COLL_DLY = 5;
`else
    localparam int COLL_DLY = 2;
`endif

    always #5 clk = ~clk;

    i2c_slave_regs_if bus();

    assign sda_line      = m_sda & (bus.sda_padoen_o | bus.sda_pad_o);
    assign bus.scl_pad_i = m_scl;
    assign bus.sda_pad_i = sda_line;

    i2c_slave_regs #(.SLAVE_ADDR(7'h50)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always @(negedge clk)
        if (bus.wr_evt_o === 1'b1)
            evt_adr.push_back(bus.wr_adr_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_scl = 1'b0; tick(8);
        m_sda = 1'b1; tick(8);
        m_scl = 1'b1; tick(16);
        m_sda = 1'b0; tick(16);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(8); m_sda = 1'b0;
        tick(8); m_scl = 1'b1;
        tick(16); m_sda = 1'b1;
        tick(16);
    endtask

    task automatic write_bit(input logic b);
        tick(8); m_sda = b;
        tick(8); m_scl = 1'b1;
        tick(16); m_scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        tick(8); m_sda = 1'b1;
        tick(8); m_scl = 1'b1;
        tick(8); b = sda_line;
        tick(8); m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic collide, output logic ack);
        for (int i = 7; i >= 1; i--)
            write_bit(d[i]);
        if (collide) begin
            tick(8); m_sda = d[0];
            tick(8); m_scl = 1'b1;
            tick(COLL_DLY);
            bus.loc_adr = 4'd5; bus.loc_dat_i = 8'h77; bus.loc_we = 1'b1;
            tick(1);
            bus.loc_we = 1'b0;
            tick(16 - COLL_DLY - 1); m_scl = 1'b0;
        end else begin
            write_bit(d[0]);
        end
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        bus.loc_adr = a; bus.loc_dat_i = d; bus.loc_we = 1'b1;
        tick(1);
        bus.loc_we = 1'b0;
    endtask

    task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
        bus.loc_adr = a;
        tick(2);
        d = bus.loc_dat_o;
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        bus.loc_adr = 4'd0; bus.loc_we = 1'b0; bus.loc_dat_i = 8'h00;
        tick(4);
        check("rst_oen", bus.sda_padoen_o, 1);
        check("rst_pad_o", bus.sda_pad_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_wr_evt", bus.wr_evt_o, 0);
        check("rst_wr_adr", bus.wr_adr_o, 0);
        check("rst_loc_dat", bus.loc_dat_o, 0);
        rst = 1'b0;
        tick(8);

        // Pointer write then two data bytes
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("w_addr_ack", ack, 0);
        check("w_busy_on", bus.busy_o, 1);
        write_byte(8'h03, 1'b0, ack); check("w_ptr_ack", ack, 0);
        write_byte(8'h11, 1'b0, ack); check("w_d0_ack", ack, 0);
        write_byte(8'h22, 1'b0, ack); check("w_d1_ack", ack, 0);
        i2c_stop();
        check("w_busy_off", bus.busy_o, 0);
        check("w_evt_count", evt_adr.size(), 2);
        check("w_evt_adr0", evt_adr[0], 3);
        check("w_evt_adr1", evt_adr[1], 4);
        loc_read(4'd3, d); check("w_reg3", d, 8'h11);
        loc_read(4'd4, d); check("w_reg4", d, 8'h22);

        // Read across the 15->0 wrap with a repeated START
        loc_write(4'd15, 8'h5A);
        loc_write(4'd0, 8'hC3);
        loc_write(4'd1, 8'h3C);
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("r_addrw_ack", ack, 0);
        write_byte(8'h0F, 1'b0, ack); check("r_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'hA1, 1'b0, ack); check("r_addrr_ack", ack, 0);
        check("r_busy_on", bus.busy_o, 1);
        read_byte(d, 1'b0); check("r_byte_reg15", d, 8'h5A);
        read_byte(d, 1'b1); check("r_byte_reg0", d, 8'hC3);
        tick(8);
        check("r_oen_after_nack", bus.sda_padoen_o, 1);
        check("r_busy_after_nack", bus.busy_o, 0);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, 1'b0, ack); check("r2_addr_ack", ack, 0);
        read_byte(d, 1'b1); check("r2_byte_reg1", d, 8'h3C);
        i2c_stop();

        // Address mismatch
        i2c_start();
        write_byte(8'hA2, 1'b0, ack); check("nm_addr_nack", ack, 1);
        check("nm_busy", bus.busy_o, 0);
        write_byte(8'h66, 1'b0, ack); check("nm_data_nack", ack, 1);
        i2c_stop();
        check("nm_evt_count", evt_adr.size(), 2);
        loc_read(4'd3, d); check("nm_reg3", d, 8'h11);

        // Local and I2C write to reg5 in the same cycle
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("c_addr_ack", ack, 0);
        write_byte(8'h05, 1'b0, ack); check("c_ptr_ack", ack, 0);
        write_byte(8'h55, 1'b1, ack); check("c_data_ack", ack, 0);
        i2c_stop();
        loc_read(4'd5, d); check("c_reg5", d, 8'h55);
        check("c_evt_count", evt_adr.size(), 3);
        check("c_evt_adr", evt_adr[2], 5);

        // Reset while the slave drives bit 4 of a read byte (reg6 = 0x00)
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("rs_addrw_ack", ack, 0);
        write_byte(8'h06, 1'b0, ack); check("rs_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'hA1, 1'b0, ack); check("rs_addrr_ack", ack, 0);
        for (int i = 0; i < 3; i++) begin
            read_bit(b); check("rs_lead_bit", b, 0);
        end
        tick(8); m_sda = 1'b1;
        tick(8); m_scl = 1'b1;
        tick(8);
        check("rs_driving", bus.sda_padoen_o, 0);
        rst = 1'b1;
        tick(1);
        check("rs_oen_released", bus.sda_padoen_o, 1);
        rst = 1'b0;
        check("rs_busy", bus.busy_o, 0);
        check("rs_wr_adr", bus.wr_adr_o, 0);
        tick(16);
        loc_read(4'd3, d); check("rs_reg3", d, 0);
        loc_read(4'd5, d); check("rs_reg5", d, 0);
        loc_read(4'd15, d); check("rs_reg15", d, 0);
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("rs2_addr_ack", ack, 0);
        write_byte(8'h07, 1'b0, ack); check("rs2_ptr_ack", ack, 0);
        write_byte(8'h9E, 1'b0, ack); check("rs2_data_ack", ack, 0);
        i2c_stop();
        loc_read(4'd7, d); check("rs2_reg7", d, 8'h9E);
        check("rs2_evt_adr", evt_adr[$], 7);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // Two-cycle SDA dip with SCL high must not look like a START
        tick(16);
        m_sda = 1'b0;
        tick(2);
        m_sda = 1'b1;
        tick(16);
        check("g_busy", bus.busy_o, 0);
        m_scl = 1'b0;
        write_byte(8'hA0, 1'b0, ack); check("g_no_start_nack", ack, 1);
        i2c_stop();
        check("g_evt_count", evt_adr.size(), 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
